// File: rtl/mem_test_checker.sv
// mem_test_checker: read-back half of the memory tester.
// After start, sweeps addresses 0..last, issues one read per address, compares each returned
// word against the selected pattern, counts mismatches (saturating) and captures the first one.
//
// Ports:
//   i_CLK, i_RST (async, active high), i_RST_CONTROL (sync clear, same effect as i_RST)
//   i_START, i_LAST_ADDR, i_PATTERN        : pass control, latched on start in idle
//   o_MEM_RD_EN, o_MEM_ADDR, i_MEM_DOUT    : memory read port
//   o_BUSY, o_DONE, o_PASS                 : status (all registered)
//   o_ERR_COUNT, o_FIRST_ERR_ADDR/DATA     : results of the last pass
module mem_test_checker #(
  parameter int unsigned p_ADDR_WIDTH   = 8,
  parameter int unsigned p_DATA_WIDTH   = 8,
  parameter int unsigned p_READ_LATENCY = 1,
  parameter int unsigned p_ERR_WIDTH    = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_RST_CONTROL,
  input  logic                    i_START,
  input  logic [p_ADDR_WIDTH-1:0] i_LAST_ADDR,
  input  logic [1:0]              i_PATTERN,
  output logic                    o_MEM_RD_EN,
  output logic [p_ADDR_WIDTH-1:0] o_MEM_ADDR,
  input  logic [p_DATA_WIDTH-1:0] i_MEM_DOUT,
  output logic                    o_BUSY,
  output logic                    o_DONE,
  output logic                    o_PASS,
  output logic [p_ERR_WIDTH-1:0]  o_ERR_COUNT,
  output logic [p_ADDR_WIDTH-1:0] o_FIRST_ERR_ADDR,
  output logic [p_DATA_WIDTH-1:0] o_FIRST_ERR_DATA
);

  localparam int unsigned ExtWidth = p_ADDR_WIDTH + p_DATA_WIDTH;

  typedef enum logic [2:0] {StIdle, StRead, StWait, StCmp, StDone} state_e;

  state_e                  state_q;
  logic [p_ADDR_WIDTH-1:0] addr_q;
  logic [p_ADDR_WIDTH-1:0] last_q;
  logic [1:0]              pattern_q;
  logic [2:0]              wait_q;
  logic                    rd_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [p_ERR_WIDTH-1:0]  err_q;
  logic [p_ADDR_WIDTH-1:0] first_addr_q;
  logic [p_DATA_WIDTH-1:0] first_data_q;

  logic [ExtWidth-1:0]     addr_ext;
  logic [p_DATA_WIDTH-1:0] walk_one;
  logic [p_DATA_WIDTH-1:0] expected;
  logic [p_ERR_WIDTH-1:0]  err_next;
  logic                    mismatch;
  int unsigned             walk_idx;

  // Expected word for the current address; only consumed in StCmp.
  always_comb begin
    // Zero-extend then take the low bits: covers both wider and narrower data.
    addr_ext = ExtWidth'(addr_q);
    walk_idx = 32'(addr_q) % p_DATA_WIDTH;
    walk_one = p_DATA_WIDTH'(1) << walk_idx;
    case (pattern_q)
      2'd0:    expected = addr_ext[p_DATA_WIDTH-1:0];
      2'd1:    expected = ~addr_ext[p_DATA_WIDTH-1:0];
      2'd2:    expected = walk_one;
      default: expected = ~walk_one;
    endcase
    mismatch = (i_MEM_DOUT != expected);
    err_next = (&err_q) ? err_q : err_q + 1'b1;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      last_q       <= '0;
      pattern_q    <= '0;
      wait_q       <= '0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      first_addr_q <= '0;
      first_data_q <= '0;
    end else if (i_RST_CONTROL) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      last_q       <= '0;
      pattern_q    <= '0;
      wait_q       <= '0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      first_addr_q <= '0;
      first_data_q <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_START) begin
            state_q      <= StRead;
            addr_q       <= '0;
            last_q       <= i_LAST_ADDR;
            pattern_q    <= i_PATTERN;
            err_q        <= '0;
            first_addr_q <= '0;
            first_data_q <= '0;
            pass_q       <= 1'b0;
            rd_en_q      <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StRead: begin
          if (p_READ_LATENCY == 1) begin
            state_q <= StCmp;
          end else begin
            state_q <= StWait;
            wait_q  <= 3'(p_READ_LATENCY - 2);
          end
        end
        StWait: begin
          if (wait_q == '0) begin
            state_q <= StCmp;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        StCmp: begin
          if (mismatch) begin
            err_q <= err_next;
            if (err_q == '0) begin
              first_addr_q <= addr_q;
              first_data_q <= i_MEM_DOUT;
            end
          end
          // Equality test terminates the sweep, so addr_q never wraps.
          if (addr_q == last_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            pass_q  <= !mismatch && (err_q == '0);
          end else begin
            state_q <= StRead;
            addr_q  <= addr_q + 1'b1;
            rd_en_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_MEM_RD_EN      = rd_en_q;
  assign o_MEM_ADDR       = addr_q;
  assign o_BUSY           = busy_q;
  assign o_DONE           = done_q;
  assign o_PASS           = pass_q;
  assign o_ERR_COUNT      = err_q;
  assign o_FIRST_ERR_ADDR = first_addr_q;
  assign o_FIRST_ERR_DATA = first_data_q;

endmodule

// File: tb/tb_mem_test_checker.sv
// Bench for mem_test_checker: two instances (latency 1 / 8-bit counter, latency 3 / 4-bit
// counter) with behavioural memories. Stimulus pushes expected pass results into a scoreboard;
// a negedge monitor checks every read request and every done pulse against it.
module tb_mem_test_checker;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NI = 2;
  localparam int SbDepth = 64;

  typedef struct {
    int inst;
    int last;
    int e;
    int errs;
    int faddr;
    int fdata;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst [NI];
  logic          rst_ctl [NI];
  logic          start [NI];
  logic          expect_idle [NI];
  logic [AW-1:0] last_addr;
  logic [1:0]    pattern;
  logic          rd_en [NI];
  logic          busy [NI];
  logic          done [NI];
  logic          pass [NI];
  logic [AW-1:0] mem_addr [NI];
  logic [DW-1:0] dout [NI];
  logic [7:0]    err_cnt [NI];
  logic [AW-1:0] faddr [NI];
  logic [DW-1:0] fdata [NI];
  logic [DW-1:0] mem [NI][256];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb [SbDepth];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   checks = 0;
  int   fails = 0;
  int   rd_idx [NI];

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int err_max(input int g);
    return (g == 0) ? 255 : 15;
  endfunction

  function automatic logic [7:0] exp_data(input int pat, input int a);
    int w;
    w = 1 << (a % 8);
    case (pat)
      0:       return 8'(a);
      1:       return 8'(255 - (a % 256));
      2:       return 8'(w);
      default: return 8'(255 - w);
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : 3;
    localparam int unsigned Ew  = (g == 0) ? 8 : 4;
    logic [Ew-1:0] err_raw;
    logic [AW-1:0] pipe [Lat];

    mem_test_checker #(
      .p_ADDR_WIDTH  (AW),
      .p_DATA_WIDTH  (DW),
      .p_READ_LATENCY(Lat),
      .p_ERR_WIDTH   (Ew)
    ) u_dut (
      .i_CLK           (clk),
      .i_RST           (rst[g]),
      .i_RST_CONTROL   (rst_ctl[g]),
      .i_START         (start[g]),
      .i_LAST_ADDR     (last_addr),
      .i_PATTERN       (pattern),
      .o_MEM_RD_EN     (rd_en[g]),
      .o_MEM_ADDR      (mem_addr[g]),
      .i_MEM_DOUT      (dout[g]),
      .o_BUSY          (busy[g]),
      .o_DONE          (done[g]),
      .o_PASS          (pass[g]),
      .o_ERR_COUNT     (err_raw),
      .o_FIRST_ERR_ADDR(faddr[g]),
      .o_FIRST_ERR_DATA(fdata[g])
    );

    assign err_cnt[g] = 8'(err_raw);

    // Address requested at the end of cycle t is visible in pipe[Lat-1] during cycle t+Lat.
    always @(posedge clk) begin
      pipe[0] <= mem_addr[g];
      for (int k = 1; k < int'(Lat); k++) pipe[k] <= pipe[k-1];
    end
    assign dout[g] = mem[g][pipe[Lat-1]];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: sole owner of the counters and of the scoreboard read pointer.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      exp_t x;
      int   pend;
      int   lat;
      lat  = lat_of(g);
      x    = sb[rd_ptr % SbDepth];
      pend = ((rd_ptr != wr_ptr) && (x.inst == g)) ? 1 : 0;
      if (expect_idle[g]) begin
        chk("idle_rd_en", int'(rd_en[g]), 0);
        chk("idle_busy", int'(busy[g]), 0);
        chk("idle_done", int'(done[g]), 0);
        chk("idle_pass", int'(pass[g]), 0);
        chk("idle_err_count", int'(err_cnt[g]), 0);
        chk("idle_first_err_addr", int'(faddr[g]), 0);
        chk("idle_first_err_data", int'(fdata[g]), 0);
        chk("idle_mem_addr", int'(mem_addr[g]), 0);
      end
      if (rst[g] || rst_ctl[g]) begin
        // An aborted pass never produces done; drop its expectation.
        if (pend != 0) rd_ptr++;
        rd_idx[g] = 0;
      end else begin
        if (rd_en[g]) begin
          chk("read_expected", pend, 1);
          if (pend != 0) begin
            chk("read_addr", int'(mem_addr[g]), rd_idx[g]);
            chk("read_cycle", int'(cyc) - x.e, rd_idx[g] * (1 + lat));
          end
          rd_idx[g]++;
        end
        if (done[g]) begin
          chk("done_expected", pend, 1);
          if (pend != 0) begin
            chk("done_cycle", int'(cyc) - x.e, (x.last + 1) * (1 + lat));
            chk("read_count", rd_idx[g], x.last + 1);
            chk("busy_in_done", int'(busy[g]), 1);
            chk("pass", int'(pass[g]), x.pass);
            chk("err_count", int'(err_cnt[g]), x.errs);
            chk("first_err_addr", int'(faddr[g]), x.faddr);
            chk("first_err_data", int'(fdata[g]), x.fdata);
            rd_ptr++;
          end
          rd_idx[g] = 0;
        end else if (pend != 0 && int'(cyc) - x.e > (x.last + 1) * (1 + lat) + 8) begin
          chk("done_timeout", int'(cyc) - x.e, (x.last + 1) * (1 + lat));
          rd_ptr++;
          rd_idx[g] = 0;
        end
      end
    end
  end

  task automatic fill(input int g, input int pat, input int pct);
    for (int a = 0; a < 256; a++) begin
      mem[g][a] = exp_data(pat, a);
      if (int'($urandom_range(0, 99)) < pct) mem[g][a] = mem[g][a] ^ 8'(1 << $urandom_range(0, 7));
    end
  endtask

  task automatic start_pass(input int g, input int last, input int pat);
    exp_t x;
    x.inst  = g;
    x.last  = last;
    x.errs  = 0;
    x.faddr = 0;
    x.fdata = 0;
    for (int a = 0; a <= last; a++) begin
      if (mem[g][a] != exp_data(pat, a)) begin
        if (x.errs == 0) begin
          x.faddr = a;
          x.fdata = int'(mem[g][a]);
        end
        x.errs++;
      end
    end
    x.pass = (x.errs == 0) ? 1 : 0;
    if (x.errs > err_max(g)) x.errs = err_max(g);
    @(negedge clk);
    last_addr = AW'(last);
    pattern   = 2'(pat);
    start[g]  = 1'b1;
    @(posedge clk);
    #1;
    x.e      = int'(cyc);
    start[g] = 1'b0;
    sb[wr_ptr % SbDepth] = x;
    wr_ptr++;
  endtask

  task automatic wait_pass();
    while (rd_ptr != wr_ptr) @(posedge clk);
  endtask

  task automatic run_pass(input int g, input int last, input int pat, input int poke);
    start_pass(g, last, pat);
    if (poke > 0) begin
      repeat (poke) @(posedge clk);
      #1 start[g] = 1'b1;
      @(posedge clk);
      #1 start[g] = 1'b0;
    end
    wait_pass();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < NI; g++) begin
      rst[g] = 1'b1;
      rst_ctl[g] = 1'b0;
      start[g] = 1'b0;
      expect_idle[g] = 1'b1;
      rd_idx[g] = 0;
    end
    last_addr = '0;
    pattern   = '0;
    fill(0, 0, 0);
    fill(1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) rst[g] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) expect_idle[g] = 1'b0;

    // Clean sweep, pattern 0, latency 1.
    fill(0, 0, 0);
    run_pass(0, 15, 0, 0);
    // Walking one with two injected errors, latency 3.
    fill(1, 2, 0);
    mem[1][5] = 8'h00;
    mem[1][9] = 8'hFF;
    run_pass(1, 15, 2, 0);
    // Range boundaries.
    run_pass(0, 0, 0, 0);
    run_pass(0, 255, 0, 0);
    // Counter saturation on the 4-bit instance.
    fill(1, 0, 100);
    run_pass(1, 31, 0, 0);
    // Start while busy must be ignored.
    fill(0, 1, 0);
    run_pass(0, 15, 1, 5);

    // Start together with the synchronous clear: stays idle.
    @(negedge clk);
    start[0]   = 1'b1;
    rst_ctl[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0]       = 1'b0;
    rst_ctl[0]     = 1'b0;
    expect_idle[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 expect_idle[0] = 1'b0;

    // Asynchronous reset during a wait cycle, then a clean pattern-3 pass.
    fill(1, 2, 30);
    start_pass(1, 15, 2);
    @(posedge clk);
    #2;
    rst[1]         = 1'b1;
    expect_idle[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1]         = 1'b0;
    expect_idle[1] = 1'b0;
    wait_pass();
    fill(1, 3, 0);
    run_pass(1, 15, 3, 0);

    // Randomized passes.
    for (int r = 0; r < 10; r++) begin
      int g;
      int pat;
      int pct;
      g   = int'($urandom_range(0, 1));
      pat = int'($urandom_range(0, 3));
      pct = (r % 3 == 0) ? 0 : ((r % 3 == 1) ? 10 : 60);
      fill(g, pat, pct);
      run_pass(g, int'($urandom_range(0, 40)), pat, 0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
